multi_channel_tick_timer: RTL and testbench
===========================================

Name: multi_channel_tick_timer

Overview:
Parametrised, multi-channel programmable tick generator. It replaces single fixed-delay down-counters for VGA frame pacing, block-drop timing and animation delays in the game. Each channel has its own period register, periodic or one-shot mode, start/stop control, and a one-cycle tick pulse. A shared load port programs all channels, and a global enable gates counting.

Parameters:
WIDTH, 26, bit width of each period/count register
CHANNELS, 4, number of independent timer channels (1..16)
CH_BITS, 2, width of load_ch; must be >= ceil(log2(CHANNELS)), minimum 1

Ports:
clk  in  1  system clock
resetn  in  1  synchronous, active-low reset
enable  in  1  global count enable; low freezes every count
load_valid  in  1  write period/mode into channel load_ch this cycle
load_ch  in  CH_BITS  target channel index for load
load_value  in  WIDTH  period value N; tick spacing is N+1 enabled cycles
load_oneshot  in  1  1 = one-shot mode, 0 = periodic mode
start  in  CHANNELS  per-channel start/restart strobe
stop  in  CHANNELS  per-channel stop strobe
tick  out  CHANNELS  registered one-cycle expiry pulse per channel
busy  out  CHANNELS  channel is in RUN
done  out  CHANNELS  sticky: one-shot channel has expired

Behaviour:
- Resetn low at a clk edge forces, for every channel:
  - period=0, mode=periodic, count=0, state IDLE
  - tick=0, busy=0, done=0
- Reset overrides all other inputs, including mid-run.
- Per-channel state machine: IDLE, RUN, DONE. busy = (state==RUN). done = (state==DONE).
- Load:
  - When load_valid=1 and load_ch<CHANNELS, period[load_ch]<=load_value and mode[load_ch]<=load_oneshot.
  - load_ch>=CHANNELS is ignored.
  - Load never alters count or state. A running channel picks up the new period at its next reload.
- Start (any state, start[i]=1, stop[i]=0):
  - count<=effective period, state<=RUN, done cleared.
  - If the same cycle loads channel i, the effective period is load_value (bypass). Otherwise it is period[i].
  - Start while RUN restarts the channel.
- Stop (stop[i]=1): state<=IDLE, count<=0, no tick.
  - Stop wins over a simultaneous start on the same channel.
  - Stop in DONE clears done.
- RUN with enable=1, no start or stop on the channel:
  - count!=0: count<=count-1.
  - count==0: tick[i]<=1 for exactly one cycle.
    - Periodic: count<=period[i] and stay in RUN.
    - One-shot: state<=DONE.
- RUN with enable=0: count holds and no tick is issued. start, stop and load still take effect.
- tick is low in every cycle not described above. It is never asserted in IDLE or DONE.
- Latency: start sampled at edge E0 with period N. tick is high in the cycle following enabled edge E(N+1). Periodic ticks then repeat every N+1 enabled edges.
- Edge cases:
  - N=0 in periodic mode: tick every enabled cycle after the first.
  - N=2^WIDTH-1 must work with no overflow. All arithmetic is unsigned WIDTH-bit with no wrap below 0.
- Channels are fully independent. Simultaneous events on different channels never interact.

Test Plan:
- Reset/idle:
  - Stimulus: hold resetn=0 for 3 cycles, release, run 20 cycles with no start.
  - Required: tick=0, busy=0 and done=0 throughout.
- Periodic timing:
  - Stimulus: load ch0 N=3 periodic, start[0], enable=1.
  - Required: tick[0] pulses in the cycles after E4, E8 and E12. Pulse width is 1 cycle. busy[0]=1 throughout.
- One-shot:
  - Stimulus: load ch1 N=5 one-shot, start[1].
  - Required: exactly one tick[1], after E6. Then busy[1]=0 and done[1]=1.
  - Follow-up: start[1] again clears done and repeats the sequence.
- Enable gating:
  - Stimulus: ch2 N=4 periodic, drop enable for 3 cycles mid-count.
  - Required: the tick is delayed by exactly 3 cycles, and no tick occurs while enable=0.
- Simultaneous events:
  - load ch3 N=7 together with start[3] on the same cycle: first tick after E8 (bypass value used).
  - start[3] together with stop[3]: channel goes to IDLE.
  - Reload of ch0 to N=1 while ch0 is running: the current period finishes at the old N, and the new spacing of 2 applies after the next tick.
- Boundaries:
  - N=0 periodic: tick every cycle after E1.
  - load_ch=CHANNELS (when not a power of 2): no channel changes.
  - resetn=0 mid-run: all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/multi_channel_tick_timer.sv
// Multi-channel programmable tick generator: per-channel period/mode, start/stop, one-cycle tick pulses.
// Start with period N gives a registered tick N+1 enabled edges later; no backpressure, every strobe is taken the cycle it arrives.
module multi_channel_tick_timer #(
    parameter int WIDTH    = 26,
    parameter int CHANNELS = 4,
    parameter int CH_BITS  = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    input  logic                load_valid,
    input  logic [CH_BITS-1:0]  load_ch,
    input  logic [WIDTH-1:0]    load_value,
    input  logic                load_oneshot,
    input  logic [CHANNELS-1:0] start,
    input  logic [CHANNELS-1:0] stop,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] r_period;
        logic [WIDTH-1:0] r_count;
        logic             r_oneshot;
        logic [1:0]       r_state;
        logic             r_tick;
        logic             w_load;

        // Out-of-range channel indices match no channel and are dropped here.
        assign w_load = load_valid && (load_ch == CH_BITS'(i));

        always_ff @(posedge clk) begin
            if (!resetn) begin
                r_period  <= '0;
                r_count   <= '0;
                r_oneshot <= 1'b0;
                r_state   <= S_IDLE;
                r_tick    <= 1'b0;
            end else begin
                r_tick <= 1'b0;
                if (w_load) begin
                    r_period  <= load_value;
                    r_oneshot <= load_oneshot;
                end
                if (stop[i]) begin
                    r_state <= S_IDLE;
                    r_count <= '0;
                end else if (start[i]) begin
                    // Same-cycle load bypasses the period register.
                    r_count <= w_load ? load_value : r_period;
                    r_state <= S_RUN;
                end else if (r_state == S_RUN && enable) begin
                    if (r_count != '0) begin
                        r_count <= r_count - WIDTH'(1);
                    end else begin
                        r_tick <= 1'b1;
                        if (r_oneshot) begin
                            r_state <= S_DONE;
                        end else begin
                            r_count <= r_period;
                        end
                    end
                end
            end
        end

        assign tick[i] = r_tick;
        assign busy[i] = (r_state == S_RUN);
        assign done[i] = (r_state == S_DONE);
    end

endmodule

// File: tb/tb_multi_channel_tick_timer.sv
// Randomized and directed bench for multi_channel_tick_timer against an edges-until-tick reference model.
module tb_multi_channel_tick_timer;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int CB = 3;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          enable = 1'b1;
    logic          load_valid = 1'b0;
    logic [CB-1:0] load_ch = '0;
    logic [W-1:0]  load_value = '0;
    logic          load_oneshot = 1'b0;
    logic [CH-1:0] start = '0;
    logic [CH-1:0] stop = '0;
    logic [CH-1:0] tick, busy, done;

    int n_checks = 0;
    int n_err    = 0;

    // Model: per channel, enabled edges left until the next tick.
    int   m_per  [CH];
    bit   m_one  [CH];
    bit   m_run  [CH];
    bit   m_done [CH];
    int   m_left [CH];
    logic [CH-1:0] m_tick;

    multi_channel_tick_timer #(.WIDTH(W), .CHANNELS(CH), .CH_BITS(CB)) dut (
        .clk(clk), .resetn(resetn), .enable(enable),
        .load_valid(load_valid), .load_ch(load_ch), .load_value(load_value),
        .load_oneshot(load_oneshot), .start(start), .stop(stop),
        .tick(tick), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        m_tick = '0;
        for (int c = 0; c < CH; c++) begin
            int  old_per;
            bit  old_one;
            bit  hit;
            old_per = m_per[c];
            old_one = m_one[c];
            hit     = load_valid && (int'(load_ch) == c);
            if (!resetn) begin
                m_per[c] = 0; m_one[c] = 0; m_run[c] = 0; m_done[c] = 0; m_left[c] = 0;
                continue;
            end
            if (hit) begin
                m_per[c] = int'(load_value);
                m_one[c] = load_oneshot;
            end
            if (stop[c]) begin
                m_run[c] = 0; m_done[c] = 0;
            end else if (start[c]) begin
                m_run[c]  = 1; m_done[c] = 0;
                m_left[c] = (hit ? int'(load_value) : old_per) + 1;
            end else if (m_run[c] && enable) begin
                m_left[c]--;
                if (m_left[c] == 0) begin
                    m_tick[c] = 1'b1;
                    if (old_one) begin
                        m_run[c] = 0; m_done[c] = 1;
                    end else begin
                        m_left[c] = old_per + 1;
                    end
                end
            end
        end
    endtask

    task automatic step();
        logic [CH-1:0] eb, ed;
        @(posedge clk);
        model_edge();
        #1;
        for (int c = 0; c < CH; c++) begin
            eb[c] = m_run[c];
            ed[c] = m_done[c];
        end
        chk("model_tick", 32'(tick), 32'(m_tick));
        chk("model_busy", 32'(busy), 32'(eb));
        chk("model_done", 32'(done), 32'(ed));
        load_valid = 1'b0;
        start      = '0;
        stop       = '0;
    endtask

    task automatic load(input int c, input int n, input bit one);
        load_valid   = 1'b1;
        load_ch      = CB'(c);
        load_value   = W'(n);
        load_oneshot = one;
    endtask

    initial begin
        // Reset and idle
        resetn = 1'b0;
        repeat (3) step();
        resetn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("idle_outs", {tick, busy, done}, 32'd0);
        end

        // Periodic ch0 N=3
        load(0, 3, 1'b0); step();
        start[0] = 1'b1; step();
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("per_tick0", tick[0], (k % 4 == 0));
            chk("per_busy0", busy[0], 1);
        end

        // One-shot ch1 N=5, twice
        load(1, 5, 1'b1); step();
        for (int rep = 0; rep < 2; rep++) begin
            start[1] = 1'b1; step();
            chk("os_restart_done", done[1], 0);
            for (int k = 1; k <= 8; k++) begin
                step();
                chk("os_tick1", tick[1], (k == 6));
            end
            chk("os_busy1", busy[1], 0);
            chk("os_done1", done[1], 1);
        end

        // Enable gating ch2 N=4
        load(2, 4, 1'b0); step();
        start[2] = 1'b1; step();
        for (int k = 1; k <= 9; k++) begin
            enable = !(k >= 3 && k <= 5);
            step();
            chk("gate_tick2", tick[2], (k == 8));
        end
        enable = 1'b1;

        // Load with start on ch3 uses bypass value
        load(3, 7, 1'b0); start[3] = 1'b1; step();
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("byp_tick3", tick[3], (k == 8));
        end
        start[3] = 1'b1; stop[3] = 1'b1; step();
        chk("startstop_busy3", busy[3], 0);

        // Reload ch0 mid-run to N=1
        start[0] = 1'b1; step();
        load(0, 1, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("reload_tick0", tick[0], (k == 4 || k == 6 || k == 8 || k == 10));
        end

        // N=0 periodic on ch2
        load(2, 0, 1'b0); start[2] = 1'b1; step();
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("n0_tick2", tick[2], 1);
        end

        // Out-of-range load_ch must not touch ch3 period (still 7)
        load(CH, 9, 1'b1); step();
        start[3] = 1'b1; step();
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("oor_tick3", tick[3], (k == 8));
        end

        // Maximum period on ch1
        load(1, (1 << W) - 1, 1'b0); start[1] = 1'b1; step();
        for (int k = 1; k <= 257; k++) begin
            step();
            if (k >= 250) chk("max_tick1", tick[1], (k == 256));
        end

        // Reset mid-run
        resetn = 1'b0; step();
        chk("rst_outs", {tick, busy, done}, 32'd0);
        resetn = 1'b1; step();

        // Random phase
        for (int k = 0; k < 4000; k++) begin
            resetn = ($urandom_range(0, 299) != 0);
            enable = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 5) == 0) begin
                load($urandom_range(0, 7),
                     ($urandom_range(0, 15) == 0) ? 255 : $urandom_range(0, 9),
                     1'($urandom_range(0, 1)));
            end
            for (int c = 0; c < CH; c++) begin
                start[c] = ($urandom_range(0, 15) == 0);
                stop[c]  = ($urandom_range(0, 40) == 0);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
